// File: rtl/bcd_pkg.sv
// Shared types and helpers for the packed-BCD to binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle between a BCD producer and the converter.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_digit_mac.sv
// Combinational multiply-accumulate step: acc*10 + digit, plus digit validity.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int ACC_W = 11
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             invalid_o
);

  // x*10 as (x<<3)+(x<<1); wraps at ACC_W, which only matters for invalid digits.
  assign acc_o     = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);
  assign invalid_o = ~is_bcd(digit_i);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock, MSD first.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic               clk,
  input  logic               reset,
  bcd_to_bin_seq_if.slave    bus
);

  // Extra headroom so an invalid digit can never corrupt the wrap behaviour of valid ones.
  localparam int ACC_W = BIN_W + 4;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if ((longint'(1) << BIN_W) < (longint'(10) ** DIGITS)) begin : g_bad_width
    $error("bcd_to_bin_seq: BIN_W too small to hold 10**DIGITS - 1");
  end

  state_e                state_q;
  logic [4*DIGITS-1:0]   opnd_q;
  logic [ACC_W-1:0]      acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_acc_q;
  logic                  busy_q;
  logic                  done_q;
  logic [BIN_W-1:0]      bin_q;
  logic                  err_q;

  logic [3:0]            digit_d;
  logic [ACC_W-1:0]      acc_d;
  logic                  digit_inv_d;
  logic                  err_acc_d;

  // Select the digit addressed by the down-counter (MSD first).
  always_comb begin
    digit_d = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) digit_d = opnd_q[4*i +: 4];
    end
  end

  bcd_digit_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc_i     (acc_q),
    .digit_i   (digit_d),
    .acc_o     (acc_d),
    .invalid_o (digit_inv_d)
  );

  assign err_acc_d = err_acc_q | digit_inv_d;

  // Control FSM with registered outputs; reset discards any in-flight conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opnd_q    <= bus.bcd_in;
            acc_q     <= '0;
            cnt_q     <= CNT_W'(DIGITS - 1);
            err_acc_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CONV: begin
          acc_q     <= acc_d;
          err_acc_q <= err_acc_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bin_q   <= err_acc_d ? '0 : acc_d[BIN_W-1:0];
            err_q   <= err_acc_d;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;

endmodule
